// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: one transfer per grant, alternating priority on ties,
// with a wait-cycle timeout that terminates a stalled transfer toward its master.
module wb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_M0 = 2'b01,
    OWN_M1 = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       last_q, last_d;   // 0 = m0 was granted last, 1 = m1
  logic [7:0] cnt_q, cnt_d;

  logic req0, req1, own_sel, own_cyc, timeout_hit;

  always_comb begin
    req0        = m0_wb_cyc_i & m0_wb_stb_i;
    req1        = m1_wb_cyc_i & m1_wb_stb_i;
    own_sel     = (state_q == OWN_M1);
    own_cyc     = own_sel ? m1_wb_cyc_i : m0_wb_cyc_i;
    timeout_hit = (state_q != IDLE) && own_cyc && !s_wb_ack_i && (cnt_q == TIMEOUT_W);

    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1)  state_d = last_q ? OWN_M0 : OWN_M1;
        else if (req0)     state_d = OWN_M0;
        else if (req1)     state_d = OWN_M1;
      end
      OWN_M0, OWN_M1: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (s_wb_ack_i || timeout_hit) begin
          state_d = IDLE;
          last_d  = own_sel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by reset so a transfer cut by reset never forwards an ack.
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    m0_wb_dat_o = s_wb_dat_i;
    m1_wb_dat_o = s_wb_dat_i;
    timeout_o   = 1'b0;
    if (!reset && state_q != IDLE) begin
      s_wb_cyc_o = own_sel ? m1_wb_cyc_i : m0_wb_cyc_i;
      s_wb_stb_o = own_sel ? m1_wb_stb_i : m0_wb_stb_i;
      s_wb_we_o  = own_sel ? m1_wb_we_i  : m0_wb_we_i;
      s_wb_adr_o = own_sel ? m1_wb_adr_i : m0_wb_adr_i;
      s_wb_dat_o = own_sel ? m1_wb_dat_i : m0_wb_dat_i;
      s_wb_sel_o = own_sel ? m1_wb_sel_i : m0_wb_sel_i;
      if (own_sel) m1_wb_ack_o = s_wb_ack_i | timeout_hit;
      else         m0_wb_ack_o = s_wb_ack_i | timeout_hit;
      if (timeout_hit) begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        timeout_o  = 1'b1;
        if (own_sel) m1_wb_dat_o = '0;
        else         m0_wb_dat_o = '0;
      end
    end
  end

  assign grant_o = state_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (TIMEOUT = 4) with hand-computed expectations.
module tb_wb_master_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;
  logic        tmo;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(m0_ack), .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(m1_ack), .m1_wb_dat_o(m1_rdat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_rdat),
    .grant_o(grant), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; s_ack = 1'b0; s_rdat = '0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 0);
    chk("rst_tmo", 32'(tmo), 0);

    // m0 single read with slave ack two cycles after cyc
    reset = 1'b0; tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0000; settle();
    chk("rd_idle_cyc", 32'(s_cyc), 0);
    tick();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_s_cyc", 32'(s_cyc), 1);
    chk("rd_s_adr", s_adr, 32'h8000_0000);
    chk("rd_s_we", 32'(s_we), 0);
    chk("rd_wait_ack", 32'(m0_ack), 0);
    tick(); tick();
    s_ack = 1; s_rdat = 32'h13; settle();
    chk("rd_m0_ack", 32'(m0_ack), 1);
    chk("rd_m0_dat", m0_rdat, 32'h13);
    chk("rd_m1_ack", 32'(m1_ack), 0);
    chk("rd_tmo", 32'(tmo), 0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0; settle();
    chk("rd_idle_after", 32'(grant), 0);
    chk("rd_idle_s_cyc", 32'(s_cyc), 0);

    // Tie right after reset: m1 first, then alternation
    reset = 1'b1; tick(); reset = 1'b0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; tick();
    chk("tie1_grant", 32'(grant), 32'h2);
    s_ack = 1; s_rdat = 32'hA1; settle();
    chk("tie1_m1_ack", 32'(m1_ack), 1);
    chk("tie1_m0_ack", 32'(m0_ack), 0);
    tick();
    m1_cyc = 0; m1_stb = 0; s_ack = 0; settle();
    chk("tie1_gap", 32'(grant), 0);
    tick();
    chk("tie2_grant", 32'(grant), 32'h1);
    s_ack = 1; settle();
    chk("tie2_m0_ack", 32'(m0_ack), 1);
    tick();
    s_ack = 0; m1_cyc = 1; m1_stb = 1; settle();
    chk("tie2_gap", 32'(grant), 0);
    tick();
    chk("tie3_grant", 32'(grant), 32'h2);
    s_ack = 1; settle();
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; settle();

    // m1 write while m0 also requests; then m0 stalls into a timeout
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h8010_0004;
    m1_dat = 32'hDEAD_BEEF; m1_sel = 4'hF; tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1234_5678; m0_dat = 32'h0BAD_F00D; m0_sel = 4'h3;
    settle();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_s_cyc", 32'(s_cyc), 1);
    chk("wr_s_stb", 32'(s_stb), 1);
    chk("wr_s_we", 32'(s_we), 1);
    chk("wr_s_adr", s_adr, 32'h8010_0004);
    chk("wr_s_dat", s_wdat, 32'hDEAD_BEEF);
    chk("wr_s_sel", 32'(s_sel), 32'hF);
    s_ack = 1; settle();
    chk("wr_m1_ack", 32'(m1_ack), 1);
    chk("wr_m0_noack", 32'(m0_ack), 0);
    tick();
    m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0; settle();
    chk("wr_gap", 32'(grant), 0);
    tick();
    chk("to_grant", 32'(grant), 32'h1);
    chk("to_wait0", 32'(tmo), 0);
    tick(); tick(); tick();
    chk("to_wait3_tmo", 32'(tmo), 0);
    chk("to_wait3_ack", 32'(m0_ack), 0);
    tick();
    s_rdat = 32'h55; settle();
    chk("to_m0_ack", 32'(m0_ack), 1);
    chk("to_m0_dat", m0_rdat, 0);
    chk("to_pulse", 32'(tmo), 1);
    chk("to_s_cyc", 32'(s_cyc), 0);
    chk("to_s_stb", 32'(s_stb), 0);
    chk("to_m1_ack", 32'(m1_ack), 0);
    tick();
    m0_cyc = 0; m0_stb = 0; settle();
    chk("to_idle", 32'(grant), 0);
    chk("to_pulse_end", 32'(tmo), 0);

    // Abort at wait cycle 1, then a late ack in IDLE
    m0_cyc = 1; m0_stb = 1; tick(); tick();
    m0_cyc = 0; m0_stb = 0; settle();
    chk("ab_noack", 32'(m0_ack), 0);
    chk("ab_s_cyc", 32'(s_cyc), 0);
    tick();
    chk("ab_idle", 32'(grant), 0);
    s_ack = 1; settle();
    chk("ab_late_acks", 32'({m0_ack, m1_ack}), 0);
    tick();
    s_ack = 0; settle();
    chk("ab_still_idle", 32'(grant), 0);

    // Reset while m1 owns the bus with an ack pending
    m1_cyc = 1; m1_stb = 1; tick();
    chk("rm_grant", 32'(grant), 32'h2);
    reset = 1; s_ack = 1; settle();
    chk("rm_rst_ack", 32'(m1_ack), 0);
    chk("rm_rst_s_cyc", 32'(s_cyc), 0);
    tick();
    chk("rm_grant0", 32'(grant), 0);
    chk("rm_post_ack", 32'(m1_ack), 0);
    reset = 0; s_ack = 0; m0_cyc = 1; m0_stb = 1; tick();
    chk("rm_tie_m1", 32'(grant), 32'h2);

    // Ack coinciding with the timeout count wins
    tick(); tick(); tick(); tick();
    s_ack = 1; s_rdat = 32'h77; settle();
    chk("co_ack", 32'(m1_ack), 1);
    chk("co_dat", m1_rdat, 32'h77);
    chk("co_no_tmo", 32'(tmo), 0);
    chk("co_s_cyc", 32'(s_cyc), 1);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m0_cyc = 0; m0_stb = 0; settle();
    chk("co_idle", 32'(grant), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning Wishbone data width; select width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for s_wb_ack_i before forced termination (1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as follows:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  IF-fetch master request.
- m0_wb_adr_i  in  ADDR_WIDTH;  m0_wb_dat_i  in  DATA_WIDTH;  m0_wb_sel_i  in  DATA_WIDTH/8.
- m0_wb_ack_o  out  1;  m0_wb_dat_o  out  DATA_WIDTH  IF-fetch master response.
- m1_wb_* (same set as m0)  MEM-stage master.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1;  s_wb_adr_o  out  ADDR_WIDTH;  s_wb_dat_o  out  DATA_WIDTH;  s_wb_sel_o  out  DATA_WIDTH/8  shared bus.
- s_wb_ack_i  in  1;  s_wb_dat_i  in  DATA_WIDTH  shared bus response.
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
- timeout_o  out  1  single-cycle pulse on forced termination.

Function
REQ-010 SHALL implement FSM states IDLE, OWN_M0, OWN_M1.
REQ-011 A master requests when cyc_i & stb_i are both 1.
REQ-012 In IDLE with exactly one master requesting, SHALL enter that master's OWN state next cycle.
REQ-013 In IDLE with both requesting, SHALL grant the master not granted last; after reset, "last" = m0, so m1 wins the first tie.
REQ-014 Arbitration latency SHALL be exactly 1 cycle: request visible at edge N -> s_wb_cyc_o = 1 during cycle N+1.
REQ-015 In OWN_x, s_wb_cyc/stb/we/adr/dat/sel_o SHALL combinationally follow master x's inputs.
REQ-016 In IDLE, s_wb_cyc_o and s_wb_stb_o SHALL be 0; s_wb_we_o SHALL be 0; other bus outputs are don't-care but driven to 0.
REQ-017 mx_wb_ack_o SHALL equal s_wb_ack_i only when state is OWN_x; non-owner ack SHALL be 0.
REQ-018 m0_wb_dat_o and m1_wb_dat_o SHALL both carry s_wb_dat_i, except during timeout termination (REQ-022).
REQ-019 One transfer per grant: on the edge where owner sees ack, SHALL return to IDLE and record the owner as "last".
REQ-020 If the owner drops cyc_i before ack (abort), SHALL return to IDLE next cycle with no ack issued.
REQ-021 A wait counter (8 bits) SHALL clear on grant and increment each OWN cycle without s_wb_ack_i.
REQ-022 Timeout: when the counter reaches TIMEOUT, SHALL in that same cycle:
- drive owner ack = 1 and owner dat_o = 0;
- force s_wb_cyc_o = s_wb_stb_o = 0;
- pulse timeout_o = 1;
- return to IDLE next cycle.
REQ-023 If s_wb_ack_i and the timeout condition coincide, the real ack SHALL take precedence: normal data, no timeout_o.
REQ-024 A new request arriving in the same cycle as an ack SHALL not be granted until the following IDLE cycle, giving one idle bus cycle between transfers.
REQ-025 grant_o SHALL be registered state, never 11.
REQ-026 An s_wb_ack_i arriving in IDLE SHALL be ignored: no master ack.

Reset
REQ-030 On reset:
- state = IDLE, last = m0, counter = 0;
- grant_o = 00, timeout_o = 0;
- all s_wb_* control outputs = 0;
- both master acks = 0.
REQ-031 Reset asserted mid-transfer SHALL abort it; no ack is forwarded in the reset cycle or the following cycle.

Verification
REQ-040 m0 alone reads 0x8000_0000; slave acks 2 cycles after cyc with 0x0000_0013 -> grant_o = 01 one cycle after request, m0 ack with 0x13, m1 ack = 0, IDLE after.
REQ-041 Both request right after reset -> m1 granted first (grant_o = 10); m0 granted on the second IDLE cycle after m1 ack; then both again -> m1 (alternation).
REQ-042 m1 write adr 0x8010_0004, dat 0xDEADBEEF, sel 0xF -> s_wb_* match exactly with we = 1; m0 requesting meanwhile sees no ack.
REQ-043 Slave never acks, TIMEOUT = 4 -> after 4 stall cycles, owner ack = 1 with dat 0, timeout_o pulses once, s_wb_cyc_o = 0, IDLE next.
REQ-044 Owner drops cyc at wait cycle 1 -> IDLE next cycle, no ack; a late slave ack is ignored.
REQ-045 Reset asserted while OWN_M1 with ack pending -> grant_o = 00, no m1 ack; first tie afterward goes to m1.
